light_monitor: RTL and testbench
================================

# light_monitor

Downstream consumer of the traffic-light FSM's `light` bus. Samples the 3-bit lamp code every clock, locks onto the RED→GREEN→YELLOW rotation, counts completed rotations and raises a sticky, coded fault on an illegal lamp code, an out-of-order transition or a phase stuck too long. Its outputs feed the status and safety logic that decides whether the intersection may keep running.

## Interface

Parameters:
- `CYC_W`, 8: width of the rotation counter.
- `MAX_DWELL`, 16: maximum consecutive samples of one phase before a STUCK fault (≥1).
- `DWELL_W`, 5: dwell counter width; must hold `MAX_DWELL`.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `light`  in  [0:2]  lamp code from the FSM: RED=3'b100, GREEN=3'b010, YELLOW=3'b001 (`light[0]` = red lamp).
- `clear`  in  1  synchronous clear of fault, counter and lock.
- `locked`  out  1  high while tracking a legal rotation.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  00 NONE, 01 ILLEGAL, 10 ORDER, 11 STUCK.
- `cycle_count`  out  CYC_W  completed rotations, wraps modulo 2^CYC_W.

## Operation

- Three states: UNLOCKED, LOCKED, FAULT. Internal registers: `prev` (last legal code), `dwell`.
- UNLOCKED: non-one-hot codes and GREEN/YELLOW are ignored; the power-up X/000 on `light` does not fault. First sampled RED → LOCKED, `prev`=RED, `dwell`=1.
- LOCKED, per sample:
  - not one-hot (000, 011, 101, 110, 111) → FAULT, code ILLEGAL.
  - one-hot, ≠`prev`, not legal successor of `prev` (RED→GREEN→YELLOW→RED) → FAULT, code ORDER.
  - equal to `prev`: if `dwell`==`MAX_DWELL` → FAULT, code STUCK; else `dwell`+1.
  - legal successor: `prev`=light, `dwell`=1; YELLOW→RED increments `cycle_count`.
- Detection priority in one sample: ILLEGAL > ORDER > STUCK.
- FAULT: sticky until `clear` or reset; `fault`=1, `fault_code` held, `locked`=0, `cycle_count` frozen, `light` ignored.
- `clear` (any state): → UNLOCKED, `fault`=0, `fault_code`=00, `cycle_count`=0, `dwell`=0. Takes priority over any fault detected in the same sample. A RED sampled with `clear` does not lock.

## Timing

- Reset values: `locked`=0, `fault`=0, `fault_code`=00, `cycle_count`=0, state UNLOCKED, `prev`=RED, `dwell`=0. Reset applies immediately, independent of `clock`, including mid-rotation or in FAULT.
- All outputs registered; latency of one edge. A code present on `light` before edge k is reflected on the outputs just after edge k.
- `locked` rises after the edge that samples the first RED.
- `cycle_count` updates after the edge that samples RED following YELLOW. Wrap from 2^CYC_W−1 to 0 is silent.
- With the FSM stepping every clock, `dwell` is always 1 and STUCK never fires.
- No combinational path from `light` or `clear` to any output.

## Structure

- Shared package `light_pkg`: lamp codes RED/GREEN/YELLOW, fault codes NONE/ILLEGAL/ORDER/STUCK, monitor state encoding, and a pure function `next_light(code)` returning the legal successor. The traffic FSM imports the same lamp codes.
- No sub-module: one state register, one `prev`/`dwell` block, one counter, all in `light_monitor`.

## Test plan

- Reset, drive RED,GREEN,YELLOW × 3 then RED → `locked`=1 after first RED edge, `cycle_count`=3, `fault`=0.
- Locked at RED, drive YELLOW → after that edge `fault`=1, `fault_code`=10, `locked`=0; further rotations leave `cycle_count` frozen.
- Drive 3'b000 in UNLOCKED → no fault; after lock drive 3'b110 → `fault_code`=01; drive 3'b110 with `clear`=1 in the same cycle → `fault`=0, UNLOCKED.
- `MAX_DWELL`=4: hold GREEN for 4 samples → no fault; 5th sample → `fault_code`=11.
- `CYC_W`=2: 5 full rotations → `cycle_count`=1; then `clear` → 0 and `locked`=0, next RED relocks.
- Assert `reset_n`=0 mid-GREEN and between edges while in FAULT → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/light_pkg.sv
// Shared lamp codes, fault codes and monitor state encoding for the traffic-light
// controller and its downstream rotation monitor.
package light_pkg;

    localparam logic [0:2] LIGHT_RED    = 3'b100;
    localparam logic [0:2] LIGHT_GREEN  = 3'b010;
    localparam logic [0:2] LIGHT_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_ORDER   = 2'b10,
        FAULT_STUCK   = 2'b11
    } fault_code_e;

    typedef enum logic [1:0] {
        MON_UNLOCKED = 2'b00,
        MON_LOCKED   = 2'b01,
        MON_FAULT    = 2'b10
    } mon_state_e;

    // Legal successor in the RED -> GREEN -> YELLOW -> RED rotation.
    function automatic logic [0:2] next_light(input logic [0:2] code);
        logic [0:2] nxt;
        nxt = LIGHT_RED;
        case (code)
            LIGHT_RED:    nxt = LIGHT_GREEN;
            LIGHT_GREEN:  nxt = LIGHT_YELLOW;
            LIGHT_YELLOW: nxt = LIGHT_RED;
            default:      nxt = LIGHT_RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/light_monitor.sv
// Watches the traffic FSM lamp bus, locks onto the legal rotation, counts completed
// rotations and latches a coded sticky fault on illegal codes, bad order or stuck phases.
module light_monitor
    import light_pkg::*;
#(
    parameter int CYC_W     = 8,
    parameter int MAX_DWELL = 16,
    parameter int DWELL_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:2]       light,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CYC_W-1:0] cycle_count
);

    mon_state_e         state_q, state_d;
    fault_code_e        code_q, code_d;
    logic [0:2]         prev_q, prev_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CYC_W-1:0]   count_q, count_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MON_UNLOCKED;
            code_q  <= FAULT_NONE;
            prev_q  <= LIGHT_RED;
            dwell_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            count_q <= count_d;
        end
    end

    // Clear outranks every detection; within LOCKED, ILLEGAL > ORDER > STUCK falls out of the if-chain.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        prev_d  = prev_q;
        dwell_d = dwell_q;
        count_d = count_q;

        if (clear) begin
            state_d = MON_UNLOCKED;
            code_d  = FAULT_NONE;
            dwell_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                MON_UNLOCKED: begin
                    if (light == LIGHT_RED) begin
                        state_d = MON_LOCKED;
                        prev_d  = LIGHT_RED;
                        dwell_d = DWELL_W'(1);
                    end
                end
                MON_LOCKED: begin
                    if (!$onehot(light)) begin
                        state_d = MON_FAULT;
                        code_d  = FAULT_ILLEGAL;
                    end else if (light == prev_q) begin
                        if (dwell_q == DWELL_W'(MAX_DWELL)) begin
                            state_d = MON_FAULT;
                            code_d  = FAULT_STUCK;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end else if (light == next_light(prev_q)) begin
                        prev_d  = light;
                        dwell_d = DWELL_W'(1);
                        if (prev_q == LIGHT_YELLOW) begin
                            count_d = count_q + CYC_W'(1);
                        end
                    end else begin
                        state_d = MON_FAULT;
                        code_d  = FAULT_ORDER;
                    end
                end
                MON_FAULT: begin
                    state_d = MON_FAULT;
                end
                default: begin
                    state_d = MON_UNLOCKED;
                end
            endcase
        end
    end

    assign locked      = (state_q == MON_LOCKED);
    assign fault       = (state_q == MON_FAULT);
    assign fault_code  = code_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_light_monitor.sv
// Directed and randomized check of light_monitor against a phase-index reference model.
module tb_light_monitor;

    localparam int TB_CYC_W     = 2;
    localparam int TB_MAX_DWELL = 4;
    localparam int TB_DWELL_W   = 3;

    logic                clock;
    logic                reset_n;
    logic [0:2]          light;
    logic                clear;
    logic                locked;
    logic                fault;
    logic [1:0]          fault_code;
    logic [TB_CYC_W-1:0] cycle_count;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 tracking, 2 faulted; phase 0=RED 1=GREEN 2=YELLOW.
    int         m_state;
    int         m_phase;
    int         m_dwell;
    int         m_count;
    logic [1:0] m_code;

    light_monitor #(
        .CYC_W    (TB_CYC_W),
        .MAX_DWELL(TB_MAX_DWELL),
        .DWELL_W  (TB_DWELL_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .light      (light),
        .clear      (clear),
        .locked     (locked),
        .fault      (fault),
        .fault_code (fault_code),
        .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int phase_of(input logic [2:0] l);
        int p;
        p = -1;
        if (l === 3'b100) p = 0;
        if (l === 3'b010) p = 1;
        if (l === 3'b001) p = 2;
        return p;
    endfunction

    function automatic logic [2:0] code_of(input int p);
        logic [2:0] c;
        c = 3'b100;
        if (p == 1) c = 3'b010;
        if (p == 2) c = 3'b001;
        return c;
    endfunction

    task automatic modelReset();
        m_state = 0;
        m_phase = 0;
        m_dwell = 0;
        m_count = 0;
        m_code  = 2'b00;
    endtask

    task automatic modelStep(input logic [2:0] l, input logic c);
        int p;
        p = phase_of(l);
        if (c) begin
            m_state = 0;
            m_code  = 2'b00;
            m_count = 0;
            m_dwell = 0;
        end else if (m_state == 0) begin
            if (p == 0) begin
                m_state = 1;
                m_phase = 0;
                m_dwell = 1;
            end
        end else if (m_state == 1) begin
            if (p < 0) begin
                m_state = 2;
                m_code  = 2'b01;
            end else if (p == m_phase) begin
                if (m_dwell >= TB_MAX_DWELL) begin
                    m_state = 2;
                    m_code  = 2'b11;
                end else begin
                    m_dwell++;
                end
            end else if (p == (m_phase + 1) % 3) begin
                if (m_phase == 2) m_count = (m_count + 1) % (1 << TB_CYC_W);
                m_phase = p;
                m_dwell = 1;
            end else begin
                m_state = 2;
                m_code  = 2'b10;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic                exp_locked;
        logic                exp_fault;
        logic [TB_CYC_W-1:0] exp_count;
        exp_locked = (m_state == 1);
        exp_fault  = (m_state == 2);
        exp_count  = TB_CYC_W'(m_count);
        checks++;
        assert (locked === exp_locked) else begin
            errors++;
            $error("[TB] FAIL %s locked: got %b expected %b", tag, locked, exp_locked);
        end
        checks++;
        assert (fault === exp_fault) else begin
            errors++;
            $error("[TB] FAIL %s fault: got %b expected %b", tag, fault, exp_fault);
        end
        checks++;
        assert (fault_code === m_code) else begin
            errors++;
            $error("[TB] FAIL %s fault_code: got %b expected %b", tag, fault_code, m_code);
        end
        checks++;
        assert (cycle_count === exp_count) else begin
            errors++;
            $error("[TB] FAIL %s cycle_count: got %0d expected %0d", tag, cycle_count, exp_count);
        end
    endtask

    // Drive one sample at the falling edge, let the rising edge take it, check 1 time unit later.
    task automatic applyStimulus(input logic [2:0] l, input logic c, input string tag);
        @(negedge clock);
        light = l;
        clear = c;
        @(posedge clock);
        modelStep(l, c);
        #1;
        checkOutput(tag);
    endtask

    // Pulse reset between edges and confirm outputs drop without any clock edge.
    task automatic asyncReset(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic rotate(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(3'b010, 1'b0, tag);
            applyStimulus(3'b001, 1'b0, tag);
            applyStimulus(3'b100, 1'b0, tag);
        end
    endtask

    initial begin
        light   = 3'b000;
        clear   = 1'b0;
        reset_n = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_state");
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(3'b000, 1'b0, "idle_000");
        applyStimulus(3'b010, 1'b0, "idle_green");
        applyStimulus(3'b100, 1'b0, "first_red_lock");
        rotate(3, "three_rotations");

        applyStimulus(3'b001, 1'b0, "red_to_yellow_order");
        rotate(3, "frozen_in_fault");

        applyStimulus(3'b110, 1'b1, "clear_from_order");
        applyStimulus(3'b000, 1'b0, "unlocked_000");
        applyStimulus(3'b100, 1'b0, "relock_red");
        applyStimulus(3'b110, 1'b0, "illegal_110");
        applyStimulus(3'b110, 1'b1, "clear_with_110");
        applyStimulus(3'b100, 1'b1, "red_with_clear_no_lock");

        applyStimulus(3'b100, 1'b0, "lock_for_dwell");
        for (int i = 0; i < TB_MAX_DWELL; i++) applyStimulus(3'b010, 1'b0, "green_hold_ok");
        applyStimulus(3'b010, 1'b0, "green_stuck");

        applyStimulus(3'b000, 1'b1, "clear_from_stuck");
        applyStimulus(3'b100, 1'b0, "lock_for_wrap");
        rotate(5, "wrap_rotations");
        applyStimulus(3'b100, 1'b1, "clear_after_wrap");
        applyStimulus(3'b100, 1'b0, "relock_after_clear");

        applyStimulus(3'b010, 1'b0, "into_green");
        asyncReset("reset_mid_green");
        applyStimulus(3'b100, 1'b0, "lock_after_reset");
        applyStimulus(3'b001, 1'b0, "order_before_reset");
        asyncReset("reset_in_fault");

        for (int i = 0; i < 400; i++) begin
            int         r;
            logic [2:0] l;
            logic       c;
            r = $urandom_range(0, 99);
            c = 1'b0;
            if (m_state == 1) l = code_of((m_phase + 1) % 3);
            else              l = 3'b100;
            if (r >= 70 && r < 85)      l = code_of(m_phase);
            else if (r >= 85 && r < 95) l = 3'($urandom_range(0, 7));
            else if (r >= 95)           c = 1'b1;
            applyStimulus(l, c, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
